// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the pe_acc processing element.
//   - pe_state_e : accumulate / drain state of the PE
//   - PE_*_W     : default operand, accumulator and result widths
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 32;
    localparam int PE_OUT_W  = 16;

    typedef enum logic {
        PE_ACCUM = 1'b0,
        PE_DRAIN = 1'b1
    } pe_state_e;

endpackage

// File: rtl/pe_round_sat.sv
// pe_round_sat: combinational round-half-up, right shift and clamp of an
// accumulator value down to the drained result width.
//   acc_val     in  ACC_W  accumulator value (two's complement or unsigned)
//   signed_mode in  1      1 = treat acc_val and result as signed
//   shift_amt   in  SH_W   right shift; rounding adds half an output LSB
//   res         out OUT_W  rounded, shifted, clamped result
//   clamped     out 1      result was limited to the output range
module pe_round_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SH_W  = $clog2(ACC_W)
) (
    input  logic [ACC_W-1:0] acc_val,
    input  logic             signed_mode,
    input  logic [SH_W-1:0]  shift_amt,
    output logic [OUT_W-1:0] res,
    output logic             clamped
);

    // Two guard bits: the rounding add can carry out of ACC_W in both modes,
    // and keeping the sum signed lets one arithmetic shift serve unsigned
    // values too (they are never negative here).
    localparam int XW = ACC_W + 2;

    localparam logic signed [XW-1:0] S_MAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] S_MIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [XW-1:0] U_MAX = {{(XW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] bias;
    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] shifted;

    always_comb begin
        ext  = {{2{signed_mode & acc_val[ACC_W-1]}}, acc_val};
        bias = '0;
        if (shift_amt != '0) begin
            bias[shift_amt - 1'b1] = 1'b1;
        end
        sum     = ext + bias;
        shifted = sum >>> shift_amt;

        res     = shifted[OUT_W-1:0];
        clamped = 1'b0;
        if (signed_mode) begin
            if (shifted > S_MAX) begin
                res     = S_MAX[OUT_W-1:0];
                clamped = 1'b1;
            end else if (shifted < S_MIN) begin
                res     = S_MIN[OUT_W-1:0];
                clamped = 1'b1;
            end
        end else if (shifted > U_MAX) begin
            res     = U_MAX[OUT_W-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/pe_acc.sv
// pe_acc: systolic-array processing element. Multiplies the west/north
// operand pair, accumulates into a wide accumulator, forwards operands east
// and south, and on drain emits a rounded/clamped result onto a result chain
// that then passes upstream results through while drain stays high.
//   clk, rst            clock; asynchronous active-high reset
//   clear               synchronous tile restart (highest priority)
//   signed_mode         1 = two's-complement operands and result
//   in_valid, a_in, b_in operand pair from neighbours
//   a_out, b_out, fwd_valid registered operands to neighbours
//   drain, shift_amt    drain request (level) and result right shift
//   c_in, c_in_valid    result chain from upstream PE
//   c_out, c_out_valid  result chain to downstream PE
//   sat_flag            sticky: a drained result was clamped
module pe_acc
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W,
    parameter int OUT_W  = PE_OUT_W,
    parameter int SH_W   = $clog2(ACC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    input  logic              drain,
    input  logic [SH_W-1:0]   shift_amt,
    input  logic [OUT_W-1:0]  c_in,
    input  logic              c_in_valid,
    output logic [OUT_W-1:0]  c_out,
    output logic              c_out_valid,
    output logic              sat_flag
);

    pe_state_e          state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  a_out_q, a_out_d;
    logic [DATA_W-1:0]  b_out_q, b_out_d;
    logic               fwd_valid_q, fwd_valid_d;
    logic [OUT_W-1:0]   c_out_q, c_out_d;
    logic               c_out_valid_q, c_out_valid_d;
    logic               sat_q, sat_d;

    logic signed [DATA_W:0]     a_x, b_x;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           acc_next;
    logic [OUT_W-1:0]           rs_res;
    logic                       rs_clamped;

    // One extra operand bit (sign copy or zero) lets a single signed
    // multiplier cover both modes; the low 2*DATA_W bits are exact either way.
    always_comb begin
        a_x      = {signed_mode & a_in[DATA_W-1], a_in};
        b_x      = {signed_mode & b_in[DATA_W-1], b_in};
        prod     = a_x * b_x;
        prod_ext = {{(ACC_W-2*DATA_W){signed_mode & prod[2*DATA_W-1]}}, prod};
        acc_next = acc_q + (in_valid ? prod_ext : '0);
    end

    pe_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) u_round_sat (
        .acc_val     (acc_next),
        .signed_mode (signed_mode),
        .shift_amt   (shift_amt),
        .res         (rs_res),
        .clamped     (rs_clamped)
    );

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_next;
        a_out_d       = a_in;
        b_out_d       = b_in;
        fwd_valid_d   = in_valid;
        c_out_d       = c_out_q;
        c_out_valid_d = 1'b0;
        sat_d         = sat_q;

        if (clear) begin
            state_d     = PE_ACCUM;
            acc_d       = '0;
            a_out_d     = '0;
            b_out_d     = '0;
            fwd_valid_d = 1'b0;
            c_out_d     = '0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                PE_ACCUM: begin
                    // Drained value includes this cycle's product; the next
                    // tile starts from zero.
                    if (drain) begin
                        c_out_d       = rs_res;
                        c_out_valid_d = 1'b1;
                        acc_d         = '0;
                        sat_d         = sat_q | rs_clamped;
                        state_d       = PE_DRAIN;
                    end
                end
                PE_DRAIN: begin
                    // Pass upstream results through while the new tile
                    // keeps accumulating.
                    if (drain) begin
                        c_out_d       = c_in;
                        c_out_valid_d = c_in_valid;
                    end else begin
                        state_d = PE_ACCUM;
                    end
                end
                default: state_d = PE_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PE_ACCUM;
            acc_q         <= '0;
            a_out_q       <= '0;
            b_out_q       <= '0;
            fwd_valid_q   <= 1'b0;
            c_out_q       <= '0;
            c_out_valid_q <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            a_out_q       <= a_out_d;
            b_out_q       <= b_out_d;
            fwd_valid_q   <= fwd_valid_d;
            c_out_q       <= c_out_d;
            c_out_valid_q <= c_out_valid_d;
            sat_q         <= sat_d;
        end
    end

    assign a_out       = a_out_q;
    assign b_out       = b_out_q;
    assign fwd_valid   = fwd_valid_q;
    assign c_out       = c_out_q;
    assign c_out_valid = c_out_valid_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_pe_acc.sv
module tb_pe_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        signed_mode;
    logic        in_valid;
    logic [7:0]  a_in, b_in;
    logic [7:0]  a_out, b_out;
    logic        fwd_valid;
    logic        drain;
    logic [4:0]  shift_amt;
    logic [15:0] c_in;
    logic        c_in_valid;
    logic [15:0] c_out;
    logic        c_out_valid;
    logic        sat_flag;

    pe_acc #(.DATA_W(8), .ACC_W(32), .OUT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .a_in        (a_in),
        .b_in        (b_in),
        .a_out       (a_out),
        .b_out       (b_out),
        .fwd_valid   (fwd_valid),
        .drain       (drain),
        .shift_amt   (shift_amt),
        .c_in        (c_in),
        .c_in_valid  (c_in_valid),
        .c_out       (c_out),
        .c_out_valid (c_out_valid),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, sm, iv;
        logic [7:0]  a, b;
        logic        drn;
        logic [4:0]  sh;
        logic [15:0] cin;
        logic        cinv;
        logic [15:0] e_cout;
        logic        e_cv, e_sat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mathematical tile sum plus a flag saying whether the
    // previous cycle was an accepted drain (chain pass-through follows).
    bit [31:0]   m_acc;
    bit          m_chain;
    logic [15:0] x_cout;
    logic        x_cv, x_sat, x_fv;
    logic [7:0]  x_a, x_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_chain = 0;
        x_cout = 0; x_cv = 0; x_sat = 0; x_fv = 0; x_a = 0; x_b = 0;
    endtask

    // Round half up at the shift, floor via arithmetic shift, then clamp.
    task automatic ref_rs(input bit [31:0] acc, input bit sm, input int sh,
                          output logic [15:0] r, output bit clamped);
        longint v, lo, hi;
        v  = sm ? longint'($signed(acc)) : longint'({32'd0, acc});
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v  = v >>> sh;
        lo = sm ? -32768 : 0;
        hi = sm ? 32767 : 65535;
        clamped = 0;
        if (v > hi) begin v = hi; clamped = 1; end
        if (v < lo) begin v = lo; clamped = 1; end
        r = v[15:0];
    endtask

    task automatic model_step(input vec_t v);
        int        p;
        bit [31:0] accn;
        logic [15:0] r;
        bit        c;
        if (v.clr) begin
            model_reset();
            return;
        end
        x_a = v.a; x_b = v.b; x_fv = v.iv;
        p    = v.sm ? int'($signed(v.a)) * int'($signed(v.b)) : int'(v.a) * int'(v.b);
        accn = m_acc + (v.iv ? 32'(p) : 32'd0);
        x_cv = 0;
        if (!m_chain) begin
            if (v.drn) begin
                ref_rs(accn, v.sm, int'(v.sh), r, c);
                x_cout = r; x_cv = 1; x_sat = x_sat | c;
                m_acc = 0; m_chain = 1;
            end else begin
                m_acc = accn;
            end
        end else begin
            m_acc = accn;
            if (v.drn) begin
                x_cout = v.cin; x_cv = v.cinv;
            end else begin
                m_chain = 0;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        clear = v.clr; signed_mode = v.sm; in_valid = v.iv;
        a_in = v.a; b_in = v.b; drain = v.drn; shift_amt = v.sh;
        c_in = v.cin; c_in_valid = v.cinv;
    endtask

    task automatic check_model();
        chk("c_out",       32'(c_out),       32'(x_cout));
        chk("c_out_valid", 32'(c_out_valid), 32'(x_cv));
        chk("sat_flag",    32'(sat_flag),    32'(x_sat));
        chk("a_out",       32'(a_out),       32'(x_a));
        chk("b_out",       32'(b_out),       32'(x_b));
        chk("fwd_valid",   32'(fwd_valid),   32'(x_fv));
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic clr, sm, iv, input logic [7:0] a, b,
                                input logic drn, input logic [4:0] sh,
                                input logic [15:0] cin, input logic cinv,
                                input logic [15:0] e_cout, input logic e_cv, e_sat);
        vec_t v;
        v.clr = clr; v.sm = sm; v.iv = iv; v.a = a; v.b = b; v.drn = drn;
        v.sh = sh; v.cin = cin; v.cinv = cinv;
        v.e_cout = e_cout; v.e_cv = e_cv; v.e_sat = e_sat;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic cur_sm;
        logic [4:0] cur_sh;
        logic drn_lvl;

        rst = 1'b1;
        drive(mk(0, 0, 0, 8'h00, 8'h00, 0, 5'd0, 16'h0000, 0, 16'h0, 0, 0));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // clr sm iv a b drn sh cin cinv | c_out cv sat
        tbl.push_back(mk(0,1,1,8'hFD,8'h05,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,1,8'hFD,8'h05,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,1,8'hFD,8'h05,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,1,8'hFD,8'h05,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'hFFC4,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'hFFC4,0,0));
        tbl.push_back(mk(0,0,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'hFFC4,0,0));
        tbl.push_back(mk(0,0,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'hFFC4,0,0));
        tbl.push_back(mk(0,0,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'hFFFF,1,1));
        tbl.push_back(mk(0,0,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'hFFFF,0,1));
        tbl.push_back(mk(1,0,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'h0002,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h0002,0,0));
        tbl.push_back(mk(0,1,1,8'h07,8'h01,0,5'd2,16'h0,0, 16'h0002,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd2,16'h0,0, 16'h0002,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd2,16'h0,0, 16'h0002,0,0));
        tbl.push_back(mk(0,1,1,8'hF9,8'h01,0,5'd2,16'h0,0, 16'h0002,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd2,16'h0,0, 16'hFFFE,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd2,16'h0,0, 16'hFFFE,0,0));
        tbl.push_back(mk(0,1,1,8'h02,8'h03,1,5'd0,16'h0,0, 16'h0006,1,0));
        tbl.push_back(mk(0,1,1,8'h01,8'h01,1,5'd0,16'h1234,1, 16'h1234,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd0,16'h5555,0, 16'h5555,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h5555,0,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'h0001,1,0));
        tbl.push_back(mk(0,1,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h0001,0,0));
        tbl.push_back(mk(0,0,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'h0001,0,0));
        tbl.push_back(mk(0,0,1,8'hFF,8'hFF,0,5'd0,16'h0,0, 16'h0001,0,0));
        tbl.push_back(mk(0,0,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'hFFFF,1,1));
        tbl.push_back(mk(0,0,1,8'h01,8'h01,1,5'd0,16'hAAAA,1, 16'hAAAA,1,1));
        tbl.push_back(mk(1,0,1,8'h09,8'h09,1,5'd0,16'hBBBB,1, 16'h0000,0,0));
        tbl.push_back(mk(0,0,1,8'h02,8'h02,0,5'd0,16'h0,0, 16'h0000,0,0));
        tbl.push_back(mk(0,0,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'h0004,1,0));
        tbl.push_back(mk(0,0,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h0004,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d.c_out", i),       32'(c_out),       32'(tbl[i].e_cout));
            chk($sformatf("tbl%0d.c_out_valid", i), 32'(c_out_valid), 32'(tbl[i].e_cv));
            chk($sformatf("tbl%0d.sat_flag", i),    32'(sat_flag),    32'(tbl[i].e_sat));
        end

        // Asynchronous reset while draining: chain contents are discarded.
        apply(mk(0,1,1,8'h03,8'h03,0,5'd0,16'h0,0, 16'h0,0,0));
        apply(mk(0,1,0,8'h00,8'h00,1,5'd0,16'h0,0, 16'h0,0,0));
        chk("pre_rst.c_out_valid", 32'(c_out_valid), 32'd1);
        chk("pre_rst.c_out",       32'(c_out),       32'h0009);
        drive(mk(0,1,1,8'h11,8'h22,1,5'd0,16'h7777,1, 16'h0,0,0));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.c_out_valid", 32'(c_out_valid), 32'd0);
        chk("async_rst.c_out",       32'(c_out),       32'd0);
        chk("async_rst.a_out",       32'(a_out),       32'd0);
        chk("async_rst.fwd_valid",   32'(fwd_valid),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            apply(mk(0,1,0,8'h00,8'h00,0,5'd0,16'h7777,1, 16'h0,0,0));
            chk("post_rst.c_out_valid", 32'(c_out_valid), 32'd0);
        end
        apply(mk(0,1,1,8'h04,8'h05,1,5'd0,16'h7777,1, 16'h0,0,0));
        chk("post_rst.drain", 32'(c_out), 32'h0014);

        // Randomized tiles; signed_mode and shift only change on clear.
        apply(mk(1,0,0,8'h00,8'h00,0,5'd0,16'h0,0, 16'h0,0,0));
        cur_sm  = 1'b1;
        cur_sh  = 5'd0;
        drn_lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            v = mk(0, cur_sm, 1'b0, 8'h00, 8'h00, 0, cur_sh, 16'h0, 0, 16'h0, 0, 0);
            v.clr = ($urandom_range(0, 49) == 0);
            if (v.clr) begin
                cur_sm = 1'($urandom_range(0, 1));
                cur_sh = 5'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 3) == 0) drn_lvl = ~drn_lvl;
            v.drn  = drn_lvl;
            v.iv   = ($urandom_range(0, 3) != 0);
            v.a    = 8'($urandom);
            v.b    = 8'($urandom);
            v.cin  = 16'($urandom);
            v.cinv = 1'($urandom_range(0, 1));
            apply(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
